// File: rtl/module_button_select.sv
// Push-button front end: synchronizes and debounces four raw buttons, emits press pulses and
// latches a one-hot group selection. Define MODULE_BUTTON_SELECT_RELEASE_CLR_EN to clear the selection on full release.
module module_button_select #(
  parameter  int DEBOUNCE_CYCLES = 100000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_button_0,
  input  logic       push_button_1,
  input  logic       push_button_2,
  input  logic       push_button_3,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] sel_onehot,
  output logic [1:0] sel_idx,
  output logic       sel_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]            raw;
  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            btn_level_q, btn_level_d;
  logic [3:0]            btn_press_q, btn_press_d;
  logic [3:0]            sel_onehot_q, sel_onehot_d;
  logic [1:0]            sel_idx_q, sel_idx_d;
  logic                  sel_valid_q, sel_valid_d;
`ifdef MODULE_BUTTON_SELECT_RELEASE_CLR_EN
  logic                  rel_q, rel_d;
`endif

  assign raw = {push_button_3, push_button_2, push_button_1, push_button_0};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // Any sample that agrees with the accepted level restarts that button's count.
  always_comb begin
    cnt_d       = cnt_q;
    btn_level_d = btn_level_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == btn_level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        btn_level_d[i] = sync2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    btn_press_d = btn_level_d & ~btn_level_q;
  end

`ifdef MODULE_BUTTON_SELECT_RELEASE_CLR_EN
  always_comb begin
    rel_d = (btn_level_q != 4'b0000) && (btn_level_d == 4'b0000);
  end
`endif

  // Press beats release-clear; descending scan leaves the lowest pressed index.
  always_comb begin
    sel_onehot_d = sel_onehot_q;
    sel_idx_d    = sel_idx_q;
    sel_valid_d  = sel_valid_q;
`ifdef MODULE_BUTTON_SELECT_RELEASE_CLR_EN
    if (rel_q) begin
      sel_onehot_d = 4'b0000;
      sel_idx_d    = 2'd0;
      sel_valid_d  = 1'b0;
    end
`endif
    if (btn_press_q != 4'b0000) begin
      sel_valid_d = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        if (btn_press_q[i]) begin
          sel_onehot_d    = 4'b0000;
          sel_onehot_d[i] = 1'b1;
          sel_idx_d       = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '0;
      btn_level_q  <= '0;
      btn_press_q  <= '0;
      sel_onehot_q <= '0;
      sel_idx_q    <= '0;
      sel_valid_q  <= 1'b0;
`ifdef MODULE_BUTTON_SELECT_RELEASE_CLR_EN
      rel_q        <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      btn_level_q  <= btn_level_d;
      btn_press_q  <= btn_press_d;
      sel_onehot_q <= sel_onehot_d;
      sel_idx_q    <= sel_idx_d;
      sel_valid_q  <= sel_valid_d;
`ifdef MODULE_BUTTON_SELECT_RELEASE_CLR_EN
      rel_q        <= rel_d;
`endif
    end
  end

  assign btn_level  = btn_level_q;
  assign btn_press  = btn_press_q;
  assign sel_onehot = sel_onehot_q;
  assign sel_idx    = sel_idx_q;
  assign sel_valid  = sel_valid_q;

endmodule
